branch_predictor: RTL and testbench

//  IF-stage dynamic branch predictor: direct-mapped BTB plus 2-bit saturating BHT.

---
 rtl/bp_pkg.sv | 46 ++++
 rtl/branch_predictor_bht.sv | 37 +++
 rtl/branch_predictor.sv | 127 ++++++++++++
 tb/tb_branch_predictor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: BHT counter states, BTB entry layout
// and the saturating-counter next-state helper.
package bp_pkg;

    localparam int BP_IDX_W   = 4;
    localparam int BP_TAG_MAX = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = WNT;

    // Tag field is sized for the smallest legal index so any IDX_W fits.
    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_MAX-1:0] tag;
        logic [31:0]           target;
    } btb_entry_t;

    function automatic bht_state_e bht_next(input bht_state_e s, input logic inc,
                                            input logic dec, input logic set_st);
        bht_state_e r;
        r = s;
        if (set_st) begin
            r = ST;
        end else if (inc) begin
            case (s)
                SNT:     r = WNT;
                WNT:     r = WT;
                default: r = ST;
            endcase
        end else if (dec) begin
            case (s)
                ST:      r = WT;
                WT:      r = WNT;
                default: r = SNT;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_bht.sv
// bht_2bit: array of 2-bit saturating direction counters with one
// combinational read port and one inc/dec/set-strong write port.
module bht_2bit
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_taken,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_inc,
    input  logic             i_wr_dec,
    input  logic             i_wr_set_st
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_state_e r_bht [ENTRIES];
    bht_state_e w_rd_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_bht[i] <= BHT_RESET;
            end
        end else if (i_wr_inc || i_wr_dec || i_wr_set_st) begin
            r_bht[i_wr_idx] <= bht_next(r_bht[i_wr_idx], i_wr_inc, i_wr_dec, i_wr_set_st);
        end
    end

    // The upper counter bit alone decides the predicted direction.
    assign w_rd_state = r_bht[i_rd_idx];
    assign o_rd_taken = w_rd_state[1];

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB plus 2-bit BHT, with EX-stage
// mispredict detection and training. Optional counters under BP_STATS_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = 30 - BP_IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    btb_entry_t r_btb [ENTRIES];

    logic [IDX_W-1:0]      w_if_idx;
    logic [IDX_W-1:0]      w_ex_idx;
    logic [BP_TAG_MAX-1:0] w_if_tag;
    logic [BP_TAG_MAX-1:0] w_ex_tag;
    btb_entry_t            w_if_entry;
    btb_entry_t            w_ex_entry;
    logic                  w_if_hit;
    logic                  w_ex_hit;
    logic                  w_if_bht_taken;
    logic                  w_ctl;
    logic                  w_noctl_pred;
    logic                  w_btb_wr;
    logic                  w_bht_inc;
    logic                  w_bht_dec;
    logic                  w_bht_set_st;
    logic [1:0]            w_unused_pc_lsb;

    assign w_unused_pc_lsb = if_pc[1:0];

    assign w_if_idx   = if_pc[IDX_W+1:2];
    assign w_ex_idx   = ex_pc[IDX_W+1:2];
    assign w_if_tag   = BP_TAG_MAX'(if_pc[31 -: TAG_W]);
    assign w_ex_tag   = BP_TAG_MAX'(ex_pc[31 -: TAG_W]);
    assign w_if_entry = r_btb[w_if_idx];
    assign w_ex_entry = r_btb[w_ex_idx];
    assign w_if_hit   = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
    assign w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);

    assign pred_taken  = w_if_hit && w_if_bht_taken;
    assign pred_target = pred_taken ? w_if_entry.target : 32'h0;

    assign w_ctl        = ex_valid && (ex_is_branch || ex_is_jump);
    assign w_noctl_pred = ex_valid && !ex_is_branch && !ex_is_jump && ex_pred_taken;

    assign mispredict = (w_ctl && ((ex_pred_taken != ex_taken) ||
                                   (ex_taken && (ex_pred_target != ex_target))))
                      || w_noctl_pred;
    assign redirect_pc = (w_ctl && ex_taken) ? ex_target : ex_pc + 32'd4;

    // Jumps take priority over the branch flag if a decoder ever sets both.
    assign w_btb_wr     = ex_valid && (ex_is_jump || (ex_is_branch && ex_taken));
    assign w_bht_set_st = ex_valid && ex_is_jump;
    assign w_bht_inc    = ex_valid && ex_is_branch && !ex_is_jump && ex_taken;
    assign w_bht_dec    = ex_valid && ex_is_branch && !ex_is_jump && !ex_taken && w_ex_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
            end
        end else if (w_btb_wr) begin
            r_btb[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag, target: ex_target};
        end else if (w_noctl_pred) begin
            r_btb[w_ex_idx].valid <= 1'b0;
        end
    end

    bht_2bit #(
        .IDX_W (IDX_W)
    ) u_bht (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rd_idx    (w_if_idx),
        .o_rd_taken  (w_if_bht_taken),
        .i_wr_idx    (w_ex_idx),
        .i_wr_inc    (w_bht_inc),
        .i_wr_dec    (w_bht_dec),
        .i_wr_set_st (w_bht_set_st)
    );

`ifdef BP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches    <= 32'h0;
            r_stat_mispredicts <= 32'h0;
        end else begin
            if (w_ctl) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (mispredict) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a vector table of one-cycle rows plus a
// hand-written reset-overlap sequence. Stats checks compile in with BP_STATS_EN.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    int unsigned exp_br  = 0;
    int unsigned exp_mis = 0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic [31:0] if_pc;
        logic        exv;
        logic [31:0] ex_pc;
        logic        br;
        logic        jmp;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[$];

    branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%08h expected=0x%08h", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] ipc, input logic v,
                                input logic [31:0] epc, input logic b, input logic j,
                                input logic t, input logic [31:0] tg, input logic pt,
                                input logic [31:0] ptg, input logic eptk,
                                input logic [31:0] eptg, input logic emis,
                                input logic [31:0] erpc);
        vec_t x;
        x.rst = r;     x.if_pc = ipc;  x.exv = v;      x.ex_pc = epc;
        x.br = b;      x.jmp = j;      x.tk = t;       x.tgt = tg;
        x.ptk = pt;    x.ptgt = ptg;   x.e_ptk = eptk; x.e_ptgt = eptg;
        x.e_mis = emis; x.e_rpc = erpc;
        return x;
    endfunction

    task automatic drive(input vec_t v);
        rst            = v.rst;
        if_pc          = v.if_pc;
        ex_valid       = v.exv;
        ex_pc          = v.ex_pc;
        ex_is_branch   = v.br;
        ex_is_jump     = v.jmp;
        ex_taken       = v.tk;
        ex_target      = v.tgt;
        ex_pred_taken  = v.ptk;
        ex_pred_target = v.ptgt;
    endtask

    // Drive one row in the low phase, check combinational outputs, let the edge update.
    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        drive(v);
        #1;
        check("pred_taken", row, 32'(pred_taken), 32'(v.e_ptk));
        check("pred_target", row, pred_target, v.e_ptgt);
        check("mispredict", row, 32'(mispredict), 32'(v.e_mis));
        if (v.e_mis) check("redirect_pc", row, redirect_pc, v.e_rpc);
`ifdef BP_STATS_EN
        check("stat_branches", row, stat_branches, exp_br);
        check("stat_mispredicts", row, stat_mispredicts, exp_mis);
        if (v.rst) begin
            exp_br  = 0;
            exp_mis = 0;
        end else begin
            if (v.exv && (v.br || v.jmp)) exp_br++;
            if (v.e_mis) exp_mis++;
        end
`endif
    endtask

    initial begin
        //        rst ifpc          v  expc          b  j  t  tgt           pt ptgt         | eptk eptgt       emis erpc
        vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h80));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h104, 1, 32'h80,  1, 32'h80,  1, 32'h104));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h104, 1, 32'h80,  1, 32'h80,  1, 32'h104));
        vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h104, 0, 32'h0,   0, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h104, 0, 32'h0,   0, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h80));
        vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h80));
        vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0));
        // untaken branches never allocate or train on a miss (0x200 aliases 0x100's index)
        vecs.push_back(mk(0, 32'h208, 1, 32'h208, 1, 0, 0, 32'h20c, 0, 32'h0,   0, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 32'h200, 1, 32'h200, 1, 0, 0, 32'h204, 0, 32'h0,   0, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0));
        // JALR retargeting
        vecs.push_back(mk(0, 32'h30c, 1, 32'h30c, 0, 1, 1, 32'h400, 0, 32'h0,   0, 32'h0,   1, 32'h400));
        vecs.push_back(mk(0, 32'h30c, 1, 32'h30c, 0, 1, 1, 32'h500, 1, 32'h400, 1, 32'h400, 1, 32'h500));
        vecs.push_back(mk(0, 32'h30c, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h500, 0, 32'h0));
        vecs.push_back(mk(0, 32'h30c, 1, 32'h30c, 0, 1, 1, 32'h500, 1, 32'h500, 1, 32'h500, 0, 32'h0));
        // non-control predicted taken: same-cycle lookup still sees the old entry
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 0, 0, 0, 32'h0,   1, 32'h80,  1, 32'h80,  1, 32'h104));
        vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
        // ex_valid low: no mispredict and no training
        vecs.push_back(mk(0, 32'h30c, 0, 32'h30c, 0, 1, 1, 32'h600, 0, 32'h0,   1, 32'h500, 0, 32'h0));
        vecs.push_back(mk(0, 32'h30c, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h500, 0, 32'h0));
        vecs.push_back(mk(0, 32'h30c, 1, 32'hfffffffc, 0, 0, 0, 32'h0, 1, 32'h0, 1, 32'h500, 1, 32'h0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h104, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h90,  0, 32'h0,   1, 32'h80));

        rst = 1'b1;
        drive(mk(1, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset in the same cycle as a jump update: lookup shows old state,
        // mispredict still flags, and nothing is written.
        @(negedge clk);
        drive(mk(1, 32'h100, 1, 32'h40c, 0, 1, 1, 32'h700, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        #1;
        check("rst_ovl_pred_taken", 100, 32'(pred_taken), 32'h1);
        check("rst_ovl_pred_target", 100, pred_target, 32'h80);
        check("rst_ovl_mispredict", 100, 32'(mispredict), 32'h1);
        check("rst_ovl_redirect", 100, redirect_pc, 32'h700);

        @(negedge clk);
        drive(mk(0, 32'h40c, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        #1;
        check("post_rst_40c", 101, 32'(pred_taken), 32'h0);
        if_pc = 32'h100;
        #1;
        check("post_rst_100", 101, 32'(pred_taken), 32'h0);
        check("post_rst_tgt_100", 101, pred_target, 32'h0);
        if_pc = 32'h30c;
        #1;
        check("post_rst_30c", 101, 32'(pred_taken), 32'h0);
`ifdef BP_STATS_EN
        check("post_rst_stat_br", 101, stat_branches, 32'h0);
        check("post_rst_stat_mis", 101, stat_mispredicts, 32'h0);
`endif

        // BHT restarts at WNT: a single taken branch must flip the prediction.
        @(negedge clk);
        drive(mk(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        #1;
        check("wnt_first_mis", 102, 32'(mispredict), 32'h1);
        @(negedge clk);
        drive(mk(0, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        #1;
        check("wnt_then_taken", 103, 32'(pred_taken), 32'h1);
        check("wnt_then_target", 103, pred_target, 32'h80);
`ifdef BP_STATS_EN
        check("final_stat_br", 103, stat_branches, 32'h1);
        check("final_stat_mis", 103, stat_mispredicts, 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
